// File: rtl/vga_framebuf.sv
// Scaled RGB332 framebuffer with a single-cycle write port and a 2-stage video read pipeline.
// Optional colour-bar generator enabled by defining VGA_FB_TESTPAT_EN.
module vga_framebuf #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_b_in,
  input  logic       wr_req,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [7:0] wr_data,
  input  logic       testpat,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_b,
  output logic       sync_b,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_ACK} wr_state_e;

  wr_state_e     state_q, state_d;
  logic          wr_err_q, wr_err_d;
  logic          mem_we;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;

  logic [7:0]    mem [DEPTH];

  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign wr_addr     = AW'(32'(wr_y) * FB_W + 32'(wr_x));
  assign wr_err      = wr_err_q;

  always_comb begin
    state_d  = state_q;
    wr_err_d = wr_err_q;
    mem_we   = 1'b0;
    wr_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          // Reset at this edge must squash the write, not just the state update.
          mem_we   = wr_in_range && !reset;
          wr_err_d = wr_err_q | ~wr_in_range;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        wr_ack  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  logic          rd_valid;
  logic [AW-1:0] rd_addr_d, rd_addr_q;
  logic          black1_q, hs1_q, vs1_q, bl1_q;
  logic [7:0]    pix_q;
  logic          black2_q, hs2_q, vs2_q, bl2_q;

  assign rd_valid  = blank_b_in && (hcnt < 10'd640) && (vcnt < 10'd480);
  assign rd_addr_d = rd_valid
                   ? AW'((32'(vcnt) >> SCALE_SHIFT) * FB_W + (32'(hcnt) >> SCALE_SHIFT))
                   : '0;

  // Memory read sits in stage 2, so a same-edge write yields the old byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      black1_q  <= 1'b1;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      bl1_q     <= 1'b0;
      pix_q     <= '0;
      black2_q  <= 1'b1;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      bl2_q     <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      black1_q  <= ~rd_valid;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
      bl1_q     <= blank_b_in;
      pix_q     <= mem[rd_addr_q];
      black2_q  <= black1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      bl2_q     <= bl1_q;
    end
  end

`ifdef VGA_FB_TESTPAT_EN
  logic [2:0] bar1_q, bar2_q;
  logic       tp1_q, tp2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bar1_q <= '0;
      bar2_q <= '0;
      tp1_q  <= 1'b0;
      tp2_q  <= 1'b0;
    end else begin
      bar1_q <= hcnt[8:6];
      bar2_q <= bar1_q;
      tp1_q  <= testpat;
      tp2_q  <= tp1_q;
    end
  end
`else
  logic unused_testpat;
  assign unused_testpat = testpat;
`endif

  always_comb begin
    r = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
    g = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
    b = {4{pix_q[1:0]}};
`ifdef VGA_FB_TESTPAT_EN
    if (tp2_q) begin
      r = {8{bar2_q[2]}};
      g = {8{bar2_q[1]}};
      b = {8{bar2_q[0]}};
    end
`endif
    if (!bl2_q || black2_q) begin
      r = '0;
      g = '0;
      b = '0;
    end
  end

  assign hsync   = hs2_q;
  assign vsync   = vs2_q;
  assign blank_b = bl2_q;
  assign sync_b  = hs2_q & vs2_q;

endmodule

// File: tb/tb_vga_framebuf.sv
// Directed bench for vga_framebuf: writes, pipelined reads, blanking, collisions, reset.
// Colour-bar checks run only when VGA_FB_TESTPAT_EN is defined.
module tb_vga_framebuf;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcnt, vcnt;
  logic       hsync_in, vsync_in, blank_b_in;
  logic       wr_req;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_data;
  logic       testpat;
  logic       wr_ack, wr_err, hsync, vsync, blank_b, sync_b;
  logic [7:0] r, g, b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0] h, v;
    logic       bl, hs, vs;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t vq[$];

  vga_framebuf dut (
    .clk(clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_b_in(blank_b_in),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .testpat(testpat),
    .wr_ack(wr_ack), .wr_err(wr_err), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .sync_b(sync_b), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void pv(input logic [9:0] h, input logic [9:0] v, input logic bl,
                             input logic hs, input logic vs,
                             input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    vec_t e;
    e.h = h; e.v = v; e.bl = bl; e.hs = hs; e.vs = vs;
    e.er = er; e.eg = eg; e.eb = eb;
    vq.push_back(e);
  endfunction

  // One vector per cycle; outputs checked two cycles after each vector is driven.
  task automatic run_stream();
    int n;
    n = vq.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("r", r, vq[i-2].er);
        chk("g", g, vq[i-2].eg);
        chk("b", b, vq[i-2].eb);
        chk("blank_b", blank_b, vq[i-2].bl);
        chk("hsync", hsync, vq[i-2].hs);
        chk("vsync", vsync, vq[i-2].vs);
        chk("sync_b", sync_b, vq[i-2].hs & vq[i-2].vs);
      end
      if (i < n) begin
        hcnt = vq[i].h; vcnt = vq[i].v; blank_b_in = vq[i].bl;
        hsync_in = vq[i].hs; vsync_in = vq[i].vs;
      end
    end
    vq.delete();
  endtask

  task automatic do_write(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d);
    int k;
    @(negedge clk);
    wr_x = x; wr_y = y; wr_data = d; wr_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wr_ack && k < 8);
    chk("wr_ack", wr_ack, 1'b1);
    chk("wr_ack_latency", k, 1);
    wr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; hcnt = 10'd40; vcnt = 10'd20;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_b_in = 1'b1;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; testpat = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_sync_b", sync_b, 1'b1);
    chk("rst_blank_b", blank_b, 1'b0);
    chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
    reset = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

    do_write(8'd10, 7'd5, 8'hE0);
    do_write(8'd11, 7'd5, 8'h1C);
    do_write(8'd12, 7'd5, 8'hB6);
    do_write(8'd2,  7'd2, 8'h03);
    for (int i = 0; i < 4; i++)
      pv(10'(40 + i), 10'(20 + i), 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    pv(10'd44, 10'd20, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00);
    pv(10'd48, 10'd20, 1'b1, 1'b1, 1'b1, 8'hB6, 8'hB6, 8'hAA);
    pv(10'd8,  10'd8,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    run_stream();

    // Held request: acks on even cycles, writes on odd cycles.
    wr_x = 8'd1; wr_y = 7'd1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      wr_data = (i <= 2) ? 8'hE0 : (i <= 4) ? 8'h1C : 8'h03;
      wr_req  = 1'b1;
      #1 chk($sformatf("held_ack_c%0d", i), wr_ack, (i % 2 == 0));
    end
    @(negedge clk);
    wr_req = 1'b0;
    pv(10'd4, 10'd4, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    run_stream();

    do_write(8'd0, 7'd0, 8'hE0);
    chk("err_before_oob", wr_err, 1'b0);
    do_write(8'd160, 7'd0, 8'hFF);
    chk("err_after_oob_x", wr_err, 1'b1);
    do_write(8'd0, 7'd120, 8'hFF);
    repeat (3) @(negedge clk);
    chk("err_sticky", wr_err, 1'b1);
    pv(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    pv(10'd4, 10'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    run_stream();

    pv(10'd40,  10'd20, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    pv(10'd700, 10'd20, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    pv(10'd41,  10'd21, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    pv(10'd42,  10'd22, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    pv(10'd40,  10'd500, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    run_stream();

    // Same-edge read and write of address 0.
    do_write(8'd0, 7'd0, 8'h03);
    @(negedge clk);
    hcnt = 10'd0; vcnt = 10'd0; blank_b_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk);
    wr_x = 8'd0; wr_y = 7'd0; wr_data = 8'h1C; wr_req = 1'b1;
    @(negedge clk);
    chk("coll_old_b", b, 8'hFF);
    chk("coll_old_g", g, 8'h00);
    chk("coll_ack", wr_ack, 1'b1);
    wr_req = 1'b0;
    @(negedge clk);
    chk("coll_new_g", g, 8'hFF);
    chk("coll_new_b", b, 8'h00);

    // Reset with a pending write to (2,2).
    @(negedge clk);
    wr_x = 8'd2; wr_y = 7'd2; wr_data = 8'hE0; wr_req = 1'b1; reset = 1'b1;
    hcnt = 10'd8; vcnt = 10'd8; blank_b_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    chk("rst2_wr_ack", wr_ack, 1'b0);
    chk("rst2_wr_err", wr_err, 1'b0);
    chk("rst2_hsync", hsync, 1'b1);
    chk("rst2_vsync", vsync, 1'b1);
    chk("rst2_sync_b", sync_b, 1'b1);
    chk("rst2_blank_b", blank_b, 1'b0);
    chk("rst2_rgb", {8'h0, r, g, b}, 32'h0);
    reset = 1'b0; wr_req = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    pv(10'd8,  10'd8,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    pv(10'd40, 10'd20, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    run_stream();
    chk("err_after_rst", wr_err, 1'b0);

    testpat = 1'b1;
`ifdef VGA_FB_TESTPAT_EN
    pv(10'd448, 10'd20, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    pv(10'd320, 10'd20, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF);
    pv(10'd64,  10'd20, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF);
    pv(10'd448, 10'd20, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
`else
    pv(10'd40,  10'd20, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
    pv(10'd448, 10'd20, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
`endif
    run_stream();
    testpat = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
